// File: rtl/rv_pipe_ctrl_if.sv
// Pipeline-to-controller bundle: stage register/status inputs towards the controller
// and the stall, flush and operand-bypass controls returned to the datapath.
interface rv_pipe_ctrl_if #(
    parameter int RA_W = 5
);
    logic [RA_W-1:0] i_decode_rs1;
    logic [RA_W-1:0] i_decode_rs2;
    logic            i_decode_inv_instr;
    logic [RA_W-1:0] i_exec_rs1;
    logic [RA_W-1:0] i_exec_rs2;
    logic [RA_W-1:0] i_exec_rd;
    logic            i_exec_load;
    logic            i_exec_br_taken;
    logic [RA_W-1:0] i_memory_rd;
    logic [RA_W-1:0] i_write_rd;
    logic            i_mem_req;
    logic            i_mem_ack;

    logic            o_fetch_pre_stall;
    logic            o_fetch_stall;
    logic            o_decode_stall;
    logic            o_decode_flush;
    logic            o_exec_stall;
    logic            o_exec_flush;
    logic [1:0]      o_exec_bp_rs1;
    logic [1:0]      o_exec_bp_rs2;

    modport master (
        output i_decode_rs1, i_decode_rs2, i_decode_inv_instr,
        output i_exec_rs1, i_exec_rs2, i_exec_rd, i_exec_load, i_exec_br_taken,
        output i_memory_rd, i_write_rd, i_mem_req, i_mem_ack,
        input  o_fetch_pre_stall, o_fetch_stall, o_decode_stall, o_decode_flush,
        input  o_exec_stall, o_exec_flush, o_exec_bp_rs1, o_exec_bp_rs2
    );

    modport slave (
        input  i_decode_rs1, i_decode_rs2, i_decode_inv_instr,
        input  i_exec_rs1, i_exec_rs2, i_exec_rd, i_exec_load, i_exec_br_taken,
        input  i_memory_rd, i_write_rd, i_mem_req, i_mem_ack,
        output o_fetch_pre_stall, o_fetch_stall, o_decode_stall, o_decode_flush,
        output o_exec_stall, o_exec_flush, o_exec_bp_rs1, o_exec_bp_rs2
    );
endinterface

// File: rtl/rv_pipe_ctrl.sv
// RISC-V core pipeline controller: either a multi-cycle stage sequencer (STAGED=1) or
// 5-stage hazard control with load-use, memory-wait, branch flush, halt and bypass.
module rv_pipe_ctrl #(
    parameter int STAGED    = 0,
    parameter int RA_W      = 5,
    parameter int RST_FLUSH = 3,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    rv_pipe_ctrl_if.slave    bus,
    output logic [2:0]       o_stage,
    output logic             o_halt,
    output logic [CNT_W-1:0] o_stall_cnt
);
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEMORY  = 3'd4,
        ST_WRITE   = 3'd5
    } stage_e;

    localparam logic [3:0]       FLUSH_INIT = 4'(RST_FLUSH);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    stage_e           stage_q, stage_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       mem_wait;
    logic       load_use;
    logic       flush_win;
    logic       fetch_pre_stall;
    logic       fetch_stall;
    logic       decode_stall;
    logic       decode_flush;
    logic       exec_stall;
    logic       exec_flush;
    logic [1:0] bp_rs1;
    logic [1:0] bp_rs2;

    // The memory stage result is younger than writeback, so it wins when both match.
    function automatic logic [1:0] bypass_sel(input logic [RA_W-1:0] rs,
                                              input logic [RA_W-1:0] mem_rd,
                                              input logic [RA_W-1:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_rd != '0 && mem_rd == rs) begin
            sel = 2'b01;
        end else if (wb_rd != '0 && wb_rd == rs) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign mem_wait  = bus.i_mem_req && !bus.i_mem_ack;
    assign load_use  = bus.i_exec_load && (bus.i_exec_rd != '0) &&
                       ((bus.i_exec_rd == bus.i_decode_rs1) || (bus.i_exec_rd == bus.i_decode_rs2));
    assign flush_win = (flush_cnt_q != 4'd0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            stage_q     <= ST_MEMORY;
            flush_cnt_q <= FLUSH_INIT;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            flush_cnt_q <= flush_cnt_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stage_d     = stage_q;
        flush_cnt_d = flush_cnt_q;
        halt_d      = halt_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_win) begin
            flush_cnt_d = flush_cnt_q - 4'd1;
        end
        if (STAGED != 0) begin
            case (stage_q)
                ST_FETCH:   stage_d = ST_DECODE;
                ST_DECODE:  stage_d = bus.i_decode_inv_instr ? ST_DECODE : ST_EXECUTE;
                ST_EXECUTE: stage_d = ST_MEMORY;
                ST_MEMORY:  stage_d = mem_wait ? ST_MEMORY : ST_WRITE;
                ST_WRITE:   stage_d = ST_FETCH;
                default:    stage_d = ST_FETCH;
            endcase
        end else begin
            if (!flush_win && !mem_wait && !bus.i_exec_br_taken && bus.i_decode_inv_instr) begin
                halt_d = 1'b1;
            end
            if (fetch_stall && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Hazard priority: reset flush window, halt, memory wait, branch, load-use.
    always_comb begin
        fetch_pre_stall = 1'b0;
        fetch_stall     = 1'b0;
        decode_stall    = 1'b0;
        decode_flush    = 1'b0;
        exec_stall      = 1'b0;
        exec_flush      = 1'b0;
        bp_rs1          = 2'b00;
        bp_rs2          = 2'b00;
        if (STAGED != 0) begin
            fetch_stall     = (stage_q != ST_FETCH);
            fetch_pre_stall = (stage_q != ST_WRITE);
            decode_flush    = (stage_q != ST_FETCH);
        end else begin
            if (flush_win) begin
                decode_flush = 1'b1;
                exec_flush   = 1'b1;
            end else if (halt_q) begin
                fetch_stall  = 1'b1;
                decode_stall = 1'b1;
                exec_flush   = 1'b1;
            end else if (mem_wait) begin
                fetch_stall  = 1'b1;
                decode_stall = 1'b1;
                exec_stall   = 1'b1;
            end else if (bus.i_exec_br_taken) begin
                decode_flush = 1'b1;
                exec_flush   = 1'b1;
            end else if (load_use) begin
                fetch_stall  = 1'b1;
                decode_stall = 1'b1;
                exec_flush   = 1'b1;
            end
            fetch_pre_stall = fetch_stall;
            bp_rs1 = bypass_sel(bus.i_exec_rs1, bus.i_memory_rd, bus.i_write_rd);
            bp_rs2 = bypass_sel(bus.i_exec_rs2, bus.i_memory_rd, bus.i_write_rd);
        end
    end

    assign bus.o_fetch_pre_stall = fetch_pre_stall;
    assign bus.o_fetch_stall     = fetch_stall;
    assign bus.o_decode_stall    = decode_stall;
    assign bus.o_decode_flush    = decode_flush;
    assign bus.o_exec_stall      = exec_stall;
    assign bus.o_exec_flush      = exec_flush;
    assign bus.o_exec_bp_rs1     = bp_rs1;
    assign bus.o_exec_bp_rs2     = bp_rs2;

    assign o_stage     = (STAGED != 0) ? 3'(stage_q) : 3'd0;
    assign o_halt      = halt_q;
    assign o_stall_cnt = stall_cnt_q;
endmodule
